video_timing_gen: RTL and testbench

Parametrised, runtime-switchable video timing generator with a scaled framebuffer address. It supports four standard modes (480p, 600p, 720p, 1080p) selectable at run time, and applies mode changes only on frame boundaries through a request/acknowledge handshake. It produces hsync/vsync/vde, per-frame and per-line markers, pixel coordinates, and an incrementally computed row-major framebuffer read address, all delayed by a configurable pipeline depth. It sits between the pixel clock domain and the framebuffer BRAM, and feeds the RGB-to-DVI encoder.

---
 rtl/video_timing_gen.sv | 134 +++++++++++++
 tb/tb_video_timing_gen.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// video_timing_gen: four-mode video timing generator with frame-boundary mode switching,
// pipelined sync/marker/coordinate outputs and a multiplier-free scaled framebuffer address.
module video_timing_gen #(
  parameter int         CNT_W        = 13,
  parameter int         ADDR_W       = 17,
  parameter int         SCALE_LOG2   = 2,
  parameter int         PIPE_DELAY   = 2,
  parameter logic [1:0] DEFAULT_MODE = 2'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [1:0]        mode_sel,
  input  logic              mode_req,
  output logic              mode_ack,
  output logic [1:0]        active_mode,
  output logic              hsync,
  output logic              vsync,
  output logic              vde,
  output logic              sof,
  output logic              eol,
  output logic              eof,
  output logic [CNT_W-1:0]  pixel_x,
  output logic [CNT_W-1:0]  pixel_y,
  output logic [ADDR_W-1:0] fbuf_addr
);
  typedef struct packed {
    logic [CNT_W-1:0] ha, hfp, hs, hbp, va, vfp, vs, vbp;
  } timing_t;
  typedef struct packed {
    logic              hsync, vsync, vde, sof, eol, eof;
    logic [CNT_W-1:0]  x, y;
    logic [ADDR_W-1:0] addr;
  } pix_t;

  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] MASK = CNT_W'((1 << SCALE_LOG2) - 1);

  function automatic timing_t tm(input int ha, hfp, hs, hbp, va, vfp, vs, vbp);
    return '{CNT_W'(ha), CNT_W'(hfp), CNT_W'(hs), CNT_W'(hbp),
             CNT_W'(va), CNT_W'(vfp), CNT_W'(vs), CNT_W'(vbp)};
  endfunction

  function automatic timing_t mode_timing(input logic [1:0] m);
    case (m)
      2'd0:    return tm(640, 8, 96, 40, 480, 2, 2, 25);
      2'd1:    return tm(800, 40, 128, 88, 600, 1, 4, 23);
      2'd2:    return tm(1280, 110, 40, 220, 720, 5, 5, 20);
      default: return tm(1920, 88, 44, 148, 1080, 4, 5, 36);
    endcase
  endfunction

  timing_t           t;
  logic [CNT_W-1:0]  h, v, ht, vt, hsa, vsa;
  logic [ADDR_W-1:0] line_base, col_off;
  logic [1:0]        pend_mode;
  logic              pend_valid, h_last, v_last, apply, de0, eol0;
  pix_t              s0;
  pix_t              pipe [PIPE_DELAY];

  always_comb begin
    t      = mode_timing(active_mode);
    ht     = t.ha + t.hfp + t.hs + t.hbp;
    vt     = t.va + t.vfp + t.vs + t.vbp;
    hsa    = t.ha + t.hfp;
    vsa    = t.va + t.vfp;
    h_last = h == ht - ONE;
    v_last = v == vt - ONE;
    apply  = pend_valid && (!enable || (h_last && v_last));
    de0    = enable && h < t.ha && v < t.va;
    eol0   = de0 && h == t.ha - ONE;
    s0.vde   = de0;
    s0.eol   = eol0;
    s0.eof   = eol0 && v == t.va - ONE;
    s0.hsync = enable && h >= hsa && h < hsa + t.hs;
    s0.vsync = enable && v >= vsa && v < vsa + t.vs;
    s0.sof   = enable && h == '0 && v == '0;
    s0.x     = de0 ? h : '0;
    s0.y     = de0 ? v : '0;
    s0.addr  = de0 ? line_base + col_off : '0;
  end

  // Address = line_base (scaled row * scaled width) + col_off (scaled column), built by accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_mode <= DEFAULT_MODE;
      pend_mode   <= '0;
      pend_valid  <= 1'b0;
      mode_ack    <= 1'b0;
      h           <= '0;
      v           <= '0;
      line_base   <= '0;
      col_off     <= '0;
    end else begin
      mode_ack   <= apply;
      pend_valid <= mode_req || (pend_valid && !apply);
      if (apply) active_mode <= pend_mode;
      if (mode_req) pend_mode <= mode_sel;
      if (!enable || (h_last && v_last)) begin
        h         <= '0;
        v         <= '0;
        line_base <= '0;
        col_off   <= '0;
      end else if (h_last) begin
        h       <= '0;
        v       <= v + ONE;
        col_off <= '0;
        if (((v + ONE) & MASK) == '0) line_base <= line_base + ADDR_W'(t.ha >> SCALE_LOG2);
      end else begin
        h <= h + ONE;
        if (h < t.ha && ((h + ONE) & MASK) == '0) col_off <= col_off + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_DELAY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= s0;
      for (int i = 1; i < PIPE_DELAY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign hsync     = pipe[PIPE_DELAY-1].hsync;
  assign vsync     = pipe[PIPE_DELAY-1].vsync;
  assign vde       = pipe[PIPE_DELAY-1].vde;
  assign sof       = pipe[PIPE_DELAY-1].sof;
  assign eol       = pipe[PIPE_DELAY-1].eol;
  assign eof       = pipe[PIPE_DELAY-1].eof;
  assign pixel_x   = pipe[PIPE_DELAY-1].x;
  assign pixel_y   = pipe[PIPE_DELAY-1].y;
  assign fbuf_addr = pipe[PIPE_DELAY-1].addr;
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: randomized bench comparing every output each cycle against a
// frame-position model (pixel index -> coordinates/syncs/address by plain arithmetic).
module tb_video_timing_gen;
  localparam int P = 2;
  localparam int HA [4] = '{640, 800, 1280, 1920};
  localparam int HF [4] = '{8, 40, 110, 88};
  localparam int HS [4] = '{96, 128, 40, 44};
  localparam int HB [4] = '{40, 88, 220, 148};
  localparam int VA [4] = '{480, 600, 720, 1080};
  localparam int VF [4] = '{2, 1, 5, 4};
  localparam int VS [4] = '{2, 4, 5, 5};
  localparam int VB [4] = '{25, 23, 20, 36};

  typedef struct packed {
    logic        hs, vs, de, sof, eol, eof;
    logic [12:0] x, y;
    logic [16:0] a;
  } ovec_t;

  logic        clk = 1'b0, rst = 1'b1, enable = 1'b0, mode_req = 1'b0;
  logic [1:0]  mode_sel = 2'd0;
  logic        mode_ack, hsync, vsync, vde, sof, eol, eof;
  logic [1:0]  active_mode;
  logic [12:0] pixel_x, pixel_y;
  logic [16:0] fbuf_addr;
  int checks = 0, failures = 0;

  video_timing_gen dut (
    .clk(clk), .rst(rst), .enable(enable), .mode_sel(mode_sel), .mode_req(mode_req),
    .mode_ack(mode_ack), .active_mode(active_mode), .hsync(hsync), .vsync(vsync),
    .vde(vde), .sof(sof), .eol(eol), .eof(eof), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .fbuf_addr(fbuf_addr)
  );

  always #5 clk = ~clk;

  function automatic int frame_len(input logic [1:0] m);
    return (HA[m] + HF[m] + HS[m] + HB[m]) * (VA[m] + VF[m] + VS[m] + VB[m]);
  endfunction

  function automatic ovec_t expect_at(input logic [1:0] m, input int t, input logic en);
    ovec_t o;
    int ht, x, y;
    o  = '0;
    ht = HA[m] + HF[m] + HS[m] + HB[m];
    x  = t % ht;
    y  = t / ht;
    if (en) begin
      o.hs  = x >= HA[m] + HF[m] && x < HA[m] + HF[m] + HS[m];
      o.vs  = y >= VA[m] + VF[m] && y < VA[m] + VF[m] + VS[m];
      o.sof = t == 0;
      if (x < HA[m] && y < VA[m]) begin
        o.de  = 1'b1;
        o.x   = 13'(x);
        o.y   = 13'(y);
        o.a   = 17'((y >> 2) * (HA[m] >> 2) + (x >> 2));
        o.eol = x == HA[m] - 1;
        o.eof = o.eol && y == VA[m] - 1;
      end
    end
    return o;
  endfunction

  // Reference: position within the frame, current/pending mode, and a P-deep output delay line.
  int         t_pos;
  logic [1:0] m_mode, m_pend;
  logic       m_pv, m_ack, m_wrap, m_app;
  ovec_t      dly [P];

  assign m_wrap = enable && t_pos == frame_len(m_mode) - 1;
  assign m_app  = m_pv && (!enable || m_wrap);

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < P; i++) dly[i] <= '0;
      t_pos <= 0; m_mode <= 2'd0; m_pend <= 2'd0; m_pv <= 1'b0; m_ack <= 1'b0;
    end else begin
      dly[0] <= expect_at(m_mode, t_pos, enable);
      for (int i = 1; i < P; i++) dly[i] <= dly[i-1];
      m_ack <= m_app;
      if (m_app) m_mode <= m_pend;
      m_pv <= mode_req || (m_pv && !m_app);
      if (mode_req) m_pend <= mode_sel;
      t_pos <= (!enable || m_wrap) ? 0 : t_pos + 1;
    end
  end

  logic [$bits(ovec_t)+2:0] got, exp;
  assign got = {mode_ack, active_mode, hsync, vsync, vde, sof, eol, eof, pixel_x, pixel_y, fbuf_addr};
  assign exp = {m_ack, m_mode, dly[P-1]};

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (got !== '0) begin failures++; $display("FAIL reset_outputs got=%h want=0", got); end
    checks++;
    if (active_mode !== 2'd0) begin failures++; $display("FAIL reset_mode got=%0d want=0", active_mode); end
  endtask

  task automatic test_480p();
    int ht = HA[0] + HF[0] + HS[0] + HB[0];
    int hs0 = HA[0] + HF[0] + P;
    @(negedge clk);
    rst = 1'b0; enable = 1'b1;
    for (int k = 1; k <= 11 * ht + 2; k++) begin
      @(negedge clk);
      checks++;
      if (got !== exp) begin failures++; $display("FAIL p480_cycle%0d got=%h want=%h", k, got, exp); end
      if (k == 1) begin
        checks++;
        if (vde !== 1'b0) begin failures++; $display("FAIL vde_early got=%b want=0", vde); end
      end
      if (k == 2) begin
        checks++;
        if ({vde, sof} !== 2'b11) begin failures++; $display("FAIL first_pixel vde_sof=%b want=11", {vde, sof}); end
      end
      if (k >= 2 && k < ht + 2) begin
        checks++;
        if (hsync !== (k >= hs0 && k < hs0 + HS[0]))
          begin failures++; $display("FAIL hsync_line0 cyc=%0d got=%b", k, hsync); end
      end
      if (k == 9 * ht + 5 + 2) begin
        checks++;
        if ({pixel_x, pixel_y, fbuf_addr} !== {13'd5, 13'd9, 17'd321})
          begin failures++; $display("FAIL addr_5_9 got=%0d,%0d,%0d want=5,9,321", pixel_x, pixel_y, fbuf_addr); end
      end
      if (k == 700 + 2) begin
        checks++;
        if ({vde, pixel_x, pixel_y, fbuf_addr} !== '0)
          begin failures++; $display("FAIL blank_zero got=%b,%0d,%0d,%0d want=0", vde, pixel_x, pixel_y, fbuf_addr); end
      end
    end
  endtask

  task automatic test_mode_1080();
    int acks = 0, last = -1;
    enable = 1'b0; mode_sel = 2'd3; mode_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      mode_req = 1'b0;
      checks++;
      if (got !== exp) begin failures++; $display("FAIL m1080_sw got=%h want=%h", got, exp); end
      if (mode_ack === 1'b1) acks++;
    end
    checks++;
    if (acks !== 1 || active_mode !== 2'd3) begin failures++; $display("FAIL m1080_ack acks=%0d mode=%0d want=1,3", acks, active_mode); end
    enable = 1'b1;
    for (int k = 1; k <= 3 * 2200 + 2; k++) begin
      @(negedge clk);
      checks++;
      if (got !== exp) begin failures++; $display("FAIL m1080_cycle%0d got=%h want=%h", k, got, exp); end
      if (eol === 1'b1) begin
        if (last >= 0) begin
          checks++;
          if (k - last !== 2200) begin failures++; $display("FAIL line_period got=%0d want=2200", k - last); end
        end
        last = k;
      end
    end
  endtask

  task automatic test_back_to_back();
    int acks = 0;
    for (int r = 0; r < 2; r++) begin
      mode_sel = r == 0 ? 2'd1 : 2'd2; mode_req = 1'b1;
      for (int k = 0; k < 500; k++) begin
        @(negedge clk);
        mode_req = 1'b0;
        checks++;
        if (got !== exp) begin failures++; $display("FAIL b2b_run got=%h want=%h", got, exp); end
        if (mode_ack === 1'b1) acks++;
      end
    end
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (got !== exp) begin failures++; $display("FAIL b2b_apply got=%h want=%h", got, exp); end
      if (mode_ack === 1'b1) acks++;
    end
    checks++;
    if (acks !== 1 || active_mode !== 2'd2) begin failures++; $display("FAIL b2b_ack acks=%0d mode=%0d want=1,2", acks, active_mode); end
  endtask

  task automatic test_enable_drop();
    int acks = 0;
    int target = 2 * (HA[2] + HF[2] + HS[2] + HB[2]) + 300;
    enable = 1'b1;
    for (int n = 0; n < 5000 && t_pos != target; n++) begin
      @(negedge clk);
      checks++;
      if (got !== exp) begin failures++; $display("FAIL drop_run got=%h want=%h", got, exp); end
    end
    checks++;
    if (t_pos != target) begin failures++; $display("FAIL drop_reach pos=%0d want=%0d", t_pos, target); end
    enable = 1'b0; mode_sel = 2'd0; mode_req = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      mode_req = 1'b0;
      checks++;
      if (got !== exp) begin failures++; $display("FAIL drop_window got=%h want=%h", got, exp); end
      if (mode_ack === 1'b1) acks++;
      if (k == 1) begin
        checks++;
        if ({vde, pixel_x, pixel_y} !== {1'b1, 13'd299, 13'd2}) begin failures++; $display("FAIL drop_lag got=%b,%0d,%0d want=1,299,2", vde, pixel_x, pixel_y); end
      end
      if (k == 2) begin
        checks++;
        if ({vde, hsync, pixel_x, fbuf_addr} !== '0) begin failures++; $display("FAIL drop_blank got=%b,%b,%0d,%0d want=0", vde, hsync, pixel_x, fbuf_addr); end
      end
    end
    checks++;
    if (acks !== 1 || active_mode !== 2'd0) begin failures++; $display("FAIL drop_ack acks=%0d mode=%0d want=1,0", acks, active_mode); end
    enable = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      checks++;
      if (got !== exp) begin failures++; $display("FAIL reen_run got=%h want=%h", got, exp); end
      if (k <= 2) begin
        checks++;
        if (sof !== (k == 2)) begin failures++; $display("FAIL reen_sof cyc=%0d got=%b", k, sof); end
      end
    end
  endtask

  task automatic test_random();
    repeat (16) begin
      enable = 1'b0; mode_sel = 2'($urandom_range(3)); mode_req = 1'b1;
      repeat ($urandom_range(2, 6)) begin
        @(negedge clk);
        mode_req = 1'b0;
        checks++;
        if (got !== exp) begin failures++; $display("FAIL rnd_idle got=%h want=%h", got, exp); end
      end
      enable = 1'b1;
      repeat ($urandom_range(100, 2500)) begin
        @(negedge clk);
        checks++;
        if (got !== exp) begin failures++; $display("FAIL rnd_run got=%h want=%h", got, exp); end
        mode_req = $urandom_range(0, 99) == 0;
        mode_sel = 2'($urandom_range(3));
        enable   = $urandom_range(0, 299) != 0;
      end
      mode_req = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    enable = 1'b0; mode_sel = 2'd2; mode_req = 1'b1;
    repeat (4) begin
      @(negedge clk);
      mode_req = 1'b0;
      checks++;
      if (got !== exp) begin failures++; $display("FAIL rmid_sw got=%h want=%h", got, exp); end
    end
    enable = 1'b1;
    repeat (1000) begin
      @(negedge clk);
      checks++;
      if (got !== exp) begin failures++; $display("FAIL rmid_run got=%h want=%h", got, exp); end
    end
    checks++;
    if (active_mode !== 2'd2) begin failures++; $display("FAIL rmid_pre mode=%0d want=2", active_mode); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (got !== '0) begin failures++; $display("FAIL rmid_zero got=%h want=0", got); end
    rst = 1'b0; enable = 1'b1;
    repeat (50) begin
      @(negedge clk);
      checks++;
      if (got !== exp) begin failures++; $display("FAIL rmid_after got=%h want=%h", got, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_480p();
    test_mode_1080();
    test_back_to_back();
    test_enable_drop();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
